memory_access: RTL and testbench

MEMORY_ACCESS -- requirements
Module: memory_access

---
 rtl/memory_access_pkg.sv | 78 +++++++
 rtl/memory_access_load_align.sv | 30 +++
 rtl/memory_access.sv | 158 +++++++++++++++
 tb/tb_memory_access.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_access_pkg.sv
// Shared RV32I type definitions for the memory-access (MA) stage.
// regfilemux : writeback mux select enum
// rv32i_ctrl : opcode enum and the pipelined control word
// rv32i_types: MA FSM states and the load/store funct3 decode
// Optional feature macro used by the MA stage: MA_MISALIGN_CHECK_EN

package regfilemux;

  typedef enum logic [3:0] {
    rf_alu_out  = 4'd0,
    rf_br_en    = 4'd1,
    rf_u_imm    = 4'd2,
    rf_lw       = 4'd3,
    rf_pc_plus4 = 4'd4,
    rf_lb       = 4'd5,
    rf_lbu      = 4'd6,
    rf_lh       = 4'd7,
    rf_lhu      = 4'd8
  } regfilemux_sel_t;

endpackage

package rv32i_ctrl;

  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011,
    op_csr   = 7'b1110011
  } rv32i_opcode;

  // Control word carried down the pipeline alongside each instruction.
  typedef struct packed {
    logic [6:0]                   opcode;
    regfilemux::regfilemux_sel_t  regfilemux_sel;
    logic                         load_regfile;
    logic [4:0]                   rd;
  } rv32i_control_word;

endpackage

package rv32i_types;

  // MA stage handshake state with the data cache.
  typedef enum logic {
    MA_IDLE = 1'b0,
    MA_BUSY = 1'b1
  } ma_state_t;

  // funct3 encodings shared by loads and stores (stores use B/H/W only).
  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } mem_funct3_t;

  // Word accesses must sit on offset 0, halfword accesses on an even offset.
  function automatic logic is_misaligned(input logic [2:0] funct3,
                                         input logic [1:0] offset);
    logic bad;
    bad = 1'b0;
    case (funct3)
      F3_W:       bad = (offset != 2'd0);
      F3_H, F3_HU: bad = offset[0];
      default:    bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/memory_access_load_align.sv
// load_align: shifts the addressed byte/halfword of a dcache word down to
// bit 0 and sign- or zero-extends it according to the load funct3.
// Purely combinational.

module load_align
  import rv32i_types::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [31:0] shifted;

  assign shifted = rdata >> {offset, 3'b000};

  // Extend the low byte/halfword of the shifted word per load type.
  always_comb begin
    data = shifted;
    case (funct3)
      F3_B:    data = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   data = {24'd0, shifted[7:0]};
      F3_H:    data = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   data = {16'd0, shifted[15:0]};
      default: data = shifted;
    endcase
  end

endmodule

// File: rtl/memory_access.sv
// memory_access: RV32I memory-access pipeline stage.
// Issues load/store requests to the data cache, stalls upstream stages
// until the cache responds, aligns load data and registers the EX/MA
// values into the MA/WB outputs.
// Optional feature: define MA_MISALIGN_CHECK_EN to suppress misaligned
// lw/lh/lhu/sw/sh accesses and flag them on misalign_out.

module memory_access
  import rv32i_types::*;
  import rv32i_ctrl::*;
(
  input  logic              clk,
  input  logic              rst,

  input  rv32i_control_word ctrl_word_in,
  input  logic [31:0]       instruction_in,
  input  logic [31:0]       PC_in,
  input  logic [31:0]       alu_in,
  input  logic [31:0]       rs2_in,
  input  logic              br_en_in,
  input  logic [3:0]        mem_byte_enable_in,
  input  logic [1:0]        addr_offset_in,

  output logic              data_read,
  output logic              data_write,
  output logic [31:0]       data_addr,
  output logic [31:0]       data_wdata,
  output logic [3:0]        data_mbe,
  input  logic              data_resp,
  input  logic [31:0]       data_rdata,

  output rv32i_control_word ctrl_word_out,
  output logic [31:0]       instruction_out,
  output logic [31:0]       PC_out,
  output logic [31:0]       alu_out,
  output logic              br_en_out,
  output logic [31:0]       mem_wb_data,
  output logic              MA_stall,
  output logic              misalign_out
);

  ma_state_t   state;
  ma_state_t   next_state;

  logic        is_load;
  logic        is_store;
  logic        is_jump;
  logic        misaligned;
  logic        mem_req;
  logic [2:0]  funct3;
  logic [31:0] load_data;
  logic [31:0] mem_wb_next;

  assign funct3   = instruction_in[14:12];
  assign is_load  = (ctrl_word_in.opcode == op_load);
  assign is_store = (ctrl_word_in.opcode == op_store);
  assign is_jump  = (ctrl_word_in.opcode == op_jal) ||
                    (ctrl_word_in.opcode == op_jalr);

`ifdef MA_MISALIGN_CHECK_EN
  assign misaligned = (is_load | is_store) & is_misaligned(funct3, addr_offset_in);
`else
  assign misaligned = 1'b0;
`endif

  // A request is only live outside reset, so a response that shows up for
  // an abandoned access (or with no access at all) cannot advance anything.
  assign mem_req    = (is_load | is_store) & ~misaligned & ~rst;
  assign data_read  = mem_req & is_load;
  assign data_write = mem_req & is_store;
  assign MA_stall   = mem_req & ~data_resp;

  assign data_addr  = {alu_in[31:2], 2'b00};
  assign data_mbe   = mem_byte_enable_in;
  assign data_wdata = rs2_in << {addr_offset_in, 3'b000};

  load_align u_load_align (
    .rdata  (data_rdata),
    .offset (addr_offset_in),
    .funct3 (funct3),
    .data   (load_data)
  );

  // FSM state register; reset abandons any outstanding access immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= MA_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state: wait in BUSY until the cache responds; a same-cycle
  // response in IDLE completes the access without leaving IDLE.
  always_comb begin
    next_state = state;
    case (state)
      MA_IDLE: begin
        if (mem_req && !data_resp) begin
          next_state = MA_BUSY;
        end
      end
      MA_BUSY: begin
        if (!mem_req || data_resp) begin
          next_state = MA_IDLE;
        end
      end
      default: next_state = MA_IDLE;
    endcase
  end

  // Writeback/forwarding value: load data, link address, branch flag or ALU.
  always_comb begin
    mem_wb_next = alu_in;
    if (misaligned) begin
      mem_wb_next = 32'd0;
    end else if (is_load) begin
      mem_wb_next = load_data;
    end else if (is_jump) begin
      mem_wb_next = PC_in + 32'd4;
    end else if (ctrl_word_in.regfilemux_sel == regfilemux::rf_br_en) begin
      mem_wb_next = {31'd0, br_en_in};
    end
  end

  // MA/WB pipeline registers advance only when the stage is not stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_word_out   <= '0;
      instruction_out <= 32'd0;
      PC_out          <= 32'd0;
      alu_out         <= 32'd0;
      br_en_out       <= 1'b0;
      mem_wb_data     <= 32'd0;
    end else if (!MA_stall) begin
      ctrl_word_out   <= ctrl_word_in;
      instruction_out <= instruction_in;
      PC_out          <= PC_in;
      alu_out         <= alu_in;
      br_en_out       <= br_en_in;
      mem_wb_data     <= mem_wb_next;
    end
  end

`ifdef MA_MISALIGN_CHECK_EN
  // Misalignment flag travels with its instruction into the MA/WB registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misalign_out <= 1'b0;
    end else if (!MA_stall) begin
      misalign_out <= misaligned;
    end
  end
`else
  assign misalign_out = 1'b0;
`endif

endmodule

// File: tb/tb_memory_access.sv
// tb_memory_access: directed, table-driven bench for the MA stage plus
// hand-written sequences for multi-cycle stalls and mid-access reset.
// The misalignment sequence is compiled only with MA_MISALIGN_CHECK_EN.

module tb_memory_access;
  import rv32i_types::*;
  import rv32i_ctrl::*;
  import regfilemux::*;

  logic              clk;
  logic              rst;
  rv32i_control_word ctrl_word_in;
  logic [31:0]       instruction_in;
  logic [31:0]       PC_in;
  logic [31:0]       alu_in;
  logic [31:0]       rs2_in;
  logic              br_en_in;
  logic [3:0]        mem_byte_enable_in;
  logic [1:0]        addr_offset_in;
  logic              data_read;
  logic              data_write;
  logic [31:0]       data_addr;
  logic [31:0]       data_wdata;
  logic [3:0]        data_mbe;
  logic              data_resp;
  logic [31:0]       data_rdata;
  rv32i_control_word ctrl_word_out;
  logic [31:0]       instruction_out;
  logic [31:0]       PC_out;
  logic [31:0]       alu_out;
  logic              br_en_out;
  logic [31:0]       mem_wb_data;
  logic              MA_stall;
  logic              misalign_out;

  int checks;
  int fails;

  memory_access dut (
    .clk                (clk),
    .rst                (rst),
    .ctrl_word_in       (ctrl_word_in),
    .instruction_in     (instruction_in),
    .PC_in              (PC_in),
    .alu_in             (alu_in),
    .rs2_in             (rs2_in),
    .br_en_in           (br_en_in),
    .mem_byte_enable_in (mem_byte_enable_in),
    .addr_offset_in     (addr_offset_in),
    .data_read          (data_read),
    .data_write         (data_write),
    .data_addr          (data_addr),
    .data_wdata         (data_wdata),
    .data_mbe           (data_mbe),
    .data_resp          (data_resp),
    .data_rdata         (data_rdata),
    .ctrl_word_out      (ctrl_word_out),
    .instruction_out    (instruction_out),
    .PC_out             (PC_out),
    .alu_out            (alu_out),
    .br_en_out          (br_en_out),
    .mem_wb_data        (mem_wb_data),
    .MA_stall           (MA_stall),
    .misalign_out       (misalign_out)
  );

  // 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [6:0]      opcode;
    regfilemux_sel_t sel;
    logic [2:0]      f3;
    logic [31:0]     alu;
    logic [31:0]     rs2;
    logic [31:0]     pc;
    logic            br;
    logic [3:0]      mbe;
    logic [1:0]      off;
    logic [31:0]     rdata;
    logic            exp_read;
    logic            exp_write;
    logic [31:0]     exp_addr;
    logic [31:0]     exp_wdata;
    logic [31:0]     exp_wb;
  } vec_t;

  vec_t vecs[15];

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Drives one instruction's EX/MA values at the falling edge.
  task automatic apply_stimulus(input logic [6:0] opcode, input regfilemux_sel_t sel,
                                input logic [2:0] f3, input logic [31:0] alu,
                                input logic [31:0] rs2, input logic [31:0] pc,
                                input logic br, input logic [3:0] mbe,
                                input logic [1:0] off, input logic [31:0] rdata,
                                input logic resp);
    @(negedge clk);
    ctrl_word_in.opcode         = opcode;
    ctrl_word_in.regfilemux_sel = sel;
    ctrl_word_in.load_regfile   = 1'b1;
    ctrl_word_in.rd             = 5'd1;
    instruction_in     = {17'd0, f3, 5'd1, opcode};
    PC_in              = pc;
    alu_in             = alu;
    rs2_in             = rs2;
    br_en_in           = br;
    mem_byte_enable_in = mbe;
    addr_offset_in     = off;
    data_rdata         = rdata;
    data_resp          = resp;
  endtask

  initial begin
    checks = 0;
    fails  = 0;

    vecs[0]  = '{op_reg,   rf_alu_out,  3'b000, 32'h0000_0010, 32'h0000_0077, 32'h0, 1'b0, 4'b0000, 2'd0, 32'h0,
                 1'b0, 1'b0, 32'h0000_0010, 32'h0000_0077, 32'h0000_0010};
    vecs[1]  = '{op_load,  rf_lhu,      3'b101, 32'h0000_2002, 32'h0, 32'h0, 1'b0, 4'b1100, 2'd2, 32'h9234_5678,
                 1'b1, 1'b0, 32'h0000_2000, 32'h0, 32'h0000_9234};
    vecs[2]  = '{op_load,  rf_lw,       3'b010, 32'h0000_3000, 32'h0, 32'h0, 1'b0, 4'b1111, 2'd0, 32'hDEAD_BEEF,
                 1'b1, 1'b0, 32'h0000_3000, 32'h0, 32'hDEAD_BEEF};
    vecs[3]  = '{op_load,  rf_lh,       3'b001, 32'h0000_3002, 32'h0, 32'h0, 1'b0, 4'b1100, 2'd2, 32'h9234_5678,
                 1'b1, 1'b0, 32'h0000_3000, 32'h0, 32'hFFFF_9234};
    vecs[4]  = '{op_load,  rf_lb,       3'b000, 32'h0000_3001, 32'h0, 32'h0, 1'b0, 4'b0010, 2'd1, 32'h1234_5678,
                 1'b1, 1'b0, 32'h0000_3000, 32'h0, 32'h0000_0056};
    vecs[5]  = '{op_load,  rf_lb,       3'b000, 32'h0000_3000, 32'h0, 32'h0, 1'b0, 4'b0001, 2'd0, 32'h0000_00F0,
                 1'b1, 1'b0, 32'h0000_3000, 32'h0, 32'hFFFF_FFF0};
    vecs[6]  = '{op_load,  rf_lbu,      3'b100, 32'h0000_3003, 32'h0, 32'h0, 1'b0, 4'b1000, 2'd3, 32'hAB00_0000,
                 1'b1, 1'b0, 32'h0000_3000, 32'h0, 32'h0000_00AB};
    vecs[7]  = '{op_store, rf_alu_out,  3'b000, 32'h0000_4001, 32'h0000_00EE, 32'h0, 1'b0, 4'b0010, 2'd1, 32'h0,
                 1'b0, 1'b1, 32'h0000_4000, 32'h0000_EE00, 32'h0000_4001};
    vecs[8]  = '{op_store, rf_alu_out,  3'b010, 32'h0000_4004, 32'hCAFE_F00D, 32'h0, 1'b0, 4'b1111, 2'd0, 32'h0,
                 1'b0, 1'b1, 32'h0000_4004, 32'hCAFE_F00D, 32'h0000_4004};
    vecs[9]  = '{op_store, rf_alu_out,  3'b000, 32'h0000_4007, 32'h1122_33EE, 32'h0, 1'b0, 4'b1000, 2'd3, 32'h0,
                 1'b0, 1'b1, 32'h0000_4004, 32'hEE00_0000, 32'h0000_4007};
    vecs[10] = '{op_jal,   rf_pc_plus4, 3'b000, 32'h0000_0200, 32'h0, 32'h0000_0100, 1'b0, 4'b0000, 2'd0, 32'h0,
                 1'b0, 1'b0, 32'h0000_0200, 32'h0, 32'h0000_0104};
    vecs[11] = '{op_jalr,  rf_pc_plus4, 3'b000, 32'h0000_0300, 32'h0, 32'hFFFF_FFFC, 1'b0, 4'b0000, 2'd0, 32'h0,
                 1'b0, 1'b0, 32'h0000_0300, 32'h0, 32'h0000_0000};
    vecs[12] = '{op_reg,   rf_br_en,    3'b010, 32'h0000_0055, 32'h0, 32'h0, 1'b1, 4'b0000, 2'd0, 32'h0,
                 1'b0, 1'b0, 32'h0000_0054, 32'h0, 32'h0000_0001};
    vecs[13] = '{op_reg,   rf_br_en,    3'b011, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b0, 4'b0000, 2'd0, 32'h0,
                 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0, 32'h0000_0000};
    vecs[14] = '{op_lui,   rf_u_imm,    3'b000, 32'h1234_5000, 32'h0, 32'h0, 1'b0, 4'b0000, 2'd0, 32'h0,
                 1'b0, 1'b0, 32'h1234_5000, 32'h0, 32'h1234_5000};

    // Reset with a load presented: no request may escape, outputs are zero.
    rst = 1'b1;
    ctrl_word_in.opcode         = op_load;
    ctrl_word_in.regfilemux_sel = rf_lw;
    ctrl_word_in.load_regfile   = 1'b1;
    ctrl_word_in.rd             = 5'd1;
    instruction_in     = {17'd0, 3'b010, 5'd1, 7'b0000011};
    PC_in              = 32'h0;
    alu_in             = 32'h0000_0100;
    rs2_in             = 32'h0;
    br_en_in           = 1'b0;
    mem_byte_enable_in = 4'b1111;
    addr_offset_in     = 2'd0;
    data_rdata         = 32'h0;
    data_resp          = 1'b0;
    #12;
    check_output("reset data_read", {31'd0, data_read}, 32'd0);
    check_output("reset MA_stall", {31'd0, MA_stall}, 32'd0);
    check_output("reset mem_wb_data", mem_wb_data, 32'd0);
    check_output("reset ctrl_word_out", {15'd0, ctrl_word_out}, 32'd0);
    check_output("reset misalign_out", {31'd0, misalign_out}, 32'd0);
    @(negedge clk);
    ctrl_word_in.opcode = op_imm;
    ctrl_word_in.regfilemux_sel = rf_alu_out;
    rst = 1'b0;

    $display("[TB] table vectors");
    for (int i = 0; i < 15; i++) begin
      apply_stimulus(vecs[i].opcode, vecs[i].sel, vecs[i].f3, vecs[i].alu, vecs[i].rs2,
                     vecs[i].pc, vecs[i].br, vecs[i].mbe, vecs[i].off, vecs[i].rdata, 1'b1);
      #1;
      check_output($sformatf("v%0d data_read", i), {31'd0, data_read}, {31'd0, vecs[i].exp_read});
      check_output($sformatf("v%0d data_write", i), {31'd0, data_write}, {31'd0, vecs[i].exp_write});
      check_output($sformatf("v%0d data_addr", i), data_addr, vecs[i].exp_addr);
      check_output($sformatf("v%0d data_wdata", i), data_wdata, vecs[i].exp_wdata);
      check_output($sformatf("v%0d data_mbe", i), {28'd0, data_mbe}, {28'd0, vecs[i].mbe});
      check_output($sformatf("v%0d MA_stall", i), {31'd0, MA_stall}, 32'd0);
      @(posedge clk);
      #1;
      check_output($sformatf("v%0d mem_wb_data", i), mem_wb_data, vecs[i].exp_wb);
      check_output($sformatf("v%0d alu_out", i), alu_out, vecs[i].alu);
      check_output($sformatf("v%0d PC_out", i), PC_out, vecs[i].pc);
      check_output($sformatf("v%0d br_en_out", i), {31'd0, br_en_out}, {31'd0, vecs[i].br});
      check_output($sformatf("v%0d instruction_out", i), instruction_out,
                   {17'd0, vecs[i].f3, 5'd1, vecs[i].opcode});
      check_output($sformatf("v%0d ctrl opcode", i), {25'd0, ctrl_word_out.opcode}, {25'd0, vecs[i].opcode});
      check_output($sformatf("v%0d misalign_out", i), {31'd0, misalign_out}, 32'd0);
    end

    // lb with three wait cycles: stall holds, outputs hold, then aligned data.
    $display("[TB] lb with delayed response");
    apply_stimulus(op_reg, rf_alu_out, 3'b000, 32'h0000_1234, 32'h0, 32'h0, 1'b0, 4'b0000, 2'd0, 32'h0, 1'b0);
    @(posedge clk);
    #1;
    check_output("pre-lb mem_wb_data", mem_wb_data, 32'h0000_1234);
    apply_stimulus(op_load, rf_lb, 3'b000, 32'h0000_1003, 32'h0, 32'h0000_0040, 1'b0, 4'b1000, 2'd3,
                   32'h80FF_FFFF, 1'b0);
    for (int c = 0; c < 3; c++) begin
      #1;
      check_output($sformatf("lb wait%0d MA_stall", c), {31'd0, MA_stall}, 32'd1);
      check_output($sformatf("lb wait%0d data_read", c), {31'd0, data_read}, 32'd1);
      check_output($sformatf("lb wait%0d data_addr", c), data_addr, 32'h0000_1000);
      @(posedge clk);
      #1;
      check_output($sformatf("lb wait%0d hold mem_wb_data", c), mem_wb_data, 32'h0000_1234);
      check_output($sformatf("lb wait%0d hold alu_out", c), alu_out, 32'h0000_1234);
      @(negedge clk);
    end
    data_resp = 1'b1;
    #1;
    check_output("lb resp MA_stall", {31'd0, MA_stall}, 32'd0);
    @(posedge clk);
    #1;
    check_output("lb mem_wb_data", mem_wb_data, 32'hFFFF_FF80);
    check_output("lb PC_out", PC_out, 32'h0000_0040);

    // sh held stable across two wait cycles.
    $display("[TB] sh with delayed response");
    apply_stimulus(op_store, rf_alu_out, 3'b001, 32'h0000_2002, 32'h0000_ABCD, 32'h0, 1'b0, 4'b1100, 2'd2,
                   32'h0, 1'b0);
    for (int c = 0; c < 2; c++) begin
      #1;
      check_output($sformatf("sh wait%0d data_write", c), {31'd0, data_write}, 32'd1);
      check_output($sformatf("sh wait%0d data_read", c), {31'd0, data_read}, 32'd0);
      check_output($sformatf("sh wait%0d data_wdata", c), data_wdata, 32'hABCD_0000);
      check_output($sformatf("sh wait%0d data_mbe", c), {28'd0, data_mbe}, 32'h0000_000C);
      check_output($sformatf("sh wait%0d MA_stall", c), {31'd0, MA_stall}, 32'd1);
      @(posedge clk);
      #1;
      check_output($sformatf("sh wait%0d hold mem_wb_data", c), mem_wb_data, 32'hFFFF_FF80);
      @(negedge clk);
    end
    data_resp = 1'b1;
    #1;
    check_output("sh resp data_write", {31'd0, data_write}, 32'd1);
    check_output("sh resp MA_stall", {31'd0, MA_stall}, 32'd0);
    @(posedge clk);
    #1;
    check_output("sh mem_wb_data", mem_wb_data, 32'h0000_2002);

    // Reset in the middle of an outstanding lw.
    $display("[TB] reset during busy lw");
    apply_stimulus(op_load, rf_lw, 3'b010, 32'h0000_5000, 32'h0, 32'h0000_0080, 1'b1, 4'b1111, 2'd0,
                   32'h5555_AAAA, 1'b0);
    @(posedge clk);
    #1;
    check_output("busy lw MA_stall", {31'd0, MA_stall}, 32'd1);
    check_output("busy lw hold mem_wb_data", mem_wb_data, 32'h0000_2002);
    #1;
    rst = 1'b1;
    #1;
    check_output("mid-reset data_read", {31'd0, data_read}, 32'd0);
    check_output("mid-reset MA_stall", {31'd0, MA_stall}, 32'd0);
    check_output("mid-reset mem_wb_data", mem_wb_data, 32'd0);
    check_output("mid-reset alu_out", alu_out, 32'd0);
    check_output("mid-reset ctrl_word_out", {15'd0, ctrl_word_out}, 32'd0);
    data_resp = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ctrl_word_in.opcode         = op_imm;
    ctrl_word_in.regfilemux_sel = rf_alu_out;
    instruction_in = {17'd0, 3'b000, 5'd1, 7'b0010011};
    alu_in         = 32'h0000_0000;
    PC_in          = 32'h0000_0084;
    #1;
    check_output("late resp data_read", {31'd0, data_read}, 32'd0);
    check_output("late resp MA_stall", {31'd0, MA_stall}, 32'd0);
    @(posedge clk);
    #1;
    check_output("late resp mem_wb_data", mem_wb_data, 32'd0);
    check_output("late resp PC_out", PC_out, 32'h0000_0084);
    apply_stimulus(op_load, rf_lw, 3'b010, 32'h0000_6000, 32'h0, 32'h0000_0088, 1'b0, 4'b1111, 2'd0,
                   32'h1122_3344, 1'b0);
    #1;
    check_output("post-reset lw data_read", {31'd0, data_read}, 32'd1);
    check_output("post-reset lw MA_stall", {31'd0, MA_stall}, 32'd1);
    check_output("post-reset lw data_addr", data_addr, 32'h0000_6000);
    @(posedge clk);
    #1;
    check_output("post-reset lw hold", mem_wb_data, 32'd0);
    @(negedge clk);
    data_resp = 1'b1;
    @(posedge clk);
    #1;
    check_output("post-reset lw mem_wb_data", mem_wb_data, 32'h1122_3344);

`ifdef MA_MISALIGN_CHECK_EN
    // Misaligned lw is swallowed: no request, no stall, flagged result of 0.
    $display("[TB] misaligned lw");
    apply_stimulus(op_load, rf_lw, 3'b010, 32'h0000_0102, 32'h0, 32'h0, 1'b0, 4'b1111, 2'd2,
                   32'hFFFF_FFFF, 1'b0);
    #1;
    check_output("misaligned lw data_read", {31'd0, data_read}, 32'd0);
    check_output("misaligned lw MA_stall", {31'd0, MA_stall}, 32'd0);
    @(posedge clk);
    #1;
    check_output("misaligned lw misalign_out", {31'd0, misalign_out}, 32'd1);
    check_output("misaligned lw mem_wb_data", mem_wb_data, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
